// File: rtl/line_render_scheduler.sv
// Per-scanline sequencer: sprite evaluation, background draw, sprite draw, with a one-cycle bus gap between phases.
// Optional macro PHASE_TIMEOUT_EN adds a per-phase watchdog and a sticky timeout_flag output.
module line_render_scheduler #(
  parameter int DISPLAY_HEIGHT    = 480,
  parameter int LINE_NUMBER_WIDTH = $clog2(DISPLAY_HEIGHT),
  parameter int TIMEOUT_CYCLES    = 1024,
  parameter int OVERRUN_CNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         line_start,
  input  logic [LINE_NUMBER_WIDTH-1:0] line_number,
  output logic [LINE_NUMBER_WIDTH-1:0] target_line,
  output logic                         eval_enable,
  input  logic                         eval_done,
  output logic                         bg_enable,
  input  logic                         bg_done,
  output logic                         spr_enable,
  input  logic                         spr_done,
  output logic [1:0]                   bus_owner,
  output logic                         buffer_select,
  output logic                         line_ready,
  output logic                         busy,
  output logic [OVERRUN_CNT_WIDTH-1:0] overrun_count
`ifdef PHASE_TIMEOUT_EN
  ,
  output logic                         timeout_flag
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EVAL = 3'd1,
    ST_GAP1 = 3'd2,
    ST_BG   = 3'd3,
    ST_GAP2 = 3'd4,
    ST_SPR  = 3'd5,
    ST_GAP3 = 3'd6,
    ST_SWAP = 3'd7
  } state_t;

  localparam logic [OVERRUN_CNT_WIDTH-1:0] OVR_MAX = {OVERRUN_CNT_WIDTH{1'b1}};

  state_t                         state_r;
  logic [LINE_NUMBER_WIDTH-1:0]   target_r;
  logic                           eval_en_r;
  logic                           bg_en_r;
  logic                           spr_en_r;
  logic [1:0]                     owner_r;
  logic                           buf_sel_r;
  logic                           ready_r;
  logic                           busy_r;
  logic [OVERRUN_CNT_WIDTH-1:0]   ovr_cnt_r;
  logic                           pend_r;
  logic [LINE_NUMBER_WIDTH-1:0]   pend_line_r;

  logic                           start_s;
  logic [LINE_NUMBER_WIDTH-1:0]   src_line_s;
  logic                           in_phase_s;
  logic                           done_raw_s;
  logic                           phase_done_s;

  // Successor line with wrap at the bottom of the visible area.
  function automatic logic [LINE_NUMBER_WIDTH-1:0] next_line(input logic [LINE_NUMBER_WIDTH-1:0] src);
    logic [LINE_NUMBER_WIDTH:0] inc;
    inc = {1'b0, src} + {{LINE_NUMBER_WIDTH{1'b0}}, 1'b1};
    if (inc == (LINE_NUMBER_WIDTH+1)'(DISPLAY_HEIGHT)) begin
      return {LINE_NUMBER_WIDTH{1'b0}};
    end else begin
      return inc[LINE_NUMBER_WIDTH-1:0];
    end
  endfunction

  // Start source selection and per-phase done qualification.
  always_comb begin
    start_s    = line_start | pend_r;
    src_line_s = line_start ? line_number : pend_line_r;
    case (state_r)
      ST_EVAL: begin
        in_phase_s = 1'b1;
        done_raw_s = eval_done;
      end
      ST_BG: begin
        in_phase_s = 1'b1;
        done_raw_s = bg_done;
      end
      ST_SPR: begin
        in_phase_s = 1'b1;
        done_raw_s = spr_done;
      end
      default: begin
        in_phase_s = 1'b0;
        done_raw_s = 1'b0;
      end
    endcase
  end

`ifdef PHASE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] phase_cnt_r;
  logic            timeout_s;
  logic            timeout_flag_r;

  // Watchdog fires on the last allowed cycle of a phase that has not seen its done.
  always_comb begin
    if (in_phase_s && !done_raw_s && (phase_cnt_r == TO_W'(TIMEOUT_CYCLES - 1))) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
    phase_done_s = done_raw_s | timeout_s;
  end

  // Phase cycle counter, zero outside phases so every phase entry starts fresh; sticky flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt_r    <= {TO_W{1'b0}};
      timeout_flag_r <= 1'b0;
    end else begin
      if (in_phase_s && !phase_done_s) begin
        phase_cnt_r <= phase_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
      end else begin
        phase_cnt_r <= {TO_W{1'b0}};
      end
      if (timeout_s) begin
        timeout_flag_r <= 1'b1;
      end else begin
        timeout_flag_r <= timeout_flag_r;
      end
    end
  end

  assign timeout_flag = timeout_flag_r;
`else
  logic [31:0] timeout_unused_s;

  assign timeout_unused_s = 32'(TIMEOUT_CYCLES);

  // Without the watchdog a phase ends only on its own done.
  always_comb begin
    phase_done_s = done_raw_s;
  end
`endif

  // Phase sequencer; all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      target_r  <= {LINE_NUMBER_WIDTH{1'b0}};
      eval_en_r <= 1'b0;
      bg_en_r   <= 1'b0;
      spr_en_r  <= 1'b0;
      owner_r   <= 2'd0;
      buf_sel_r <= 1'b0;
      ready_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      ready_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r   <= ST_EVAL;
            target_r  <= next_line(src_line_s);
            eval_en_r <= 1'b1;
            owner_r   <= 2'd1;
            busy_r    <= 1'b1;
          end
        end
        ST_EVAL: begin
          if (phase_done_s) begin
            state_r   <= ST_GAP1;
            eval_en_r <= 1'b0;
            owner_r   <= 2'd0;
          end
        end
        ST_GAP1: begin
          state_r <= ST_BG;
          bg_en_r <= 1'b1;
          owner_r <= 2'd2;
        end
        ST_BG: begin
          if (phase_done_s) begin
            state_r <= ST_GAP2;
            bg_en_r <= 1'b0;
            owner_r <= 2'd0;
          end
        end
        ST_GAP2: begin
          state_r  <= ST_SPR;
          spr_en_r <= 1'b1;
          owner_r  <= 2'd3;
        end
        ST_SPR: begin
          if (phase_done_s) begin
            state_r  <= ST_GAP3;
            spr_en_r <= 1'b0;
            owner_r  <= 2'd0;
          end
        end
        ST_GAP3: begin
          state_r   <= ST_SWAP;
          buf_sel_r <= ~buf_sel_r;
          ready_r   <= 1'b1;
        end
        ST_SWAP: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          eval_en_r <= 1'b0;
          bg_en_r   <= 1'b0;
          spr_en_r  <= 1'b0;
          owner_r   <= 2'd0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  // One-deep queue for a start arriving mid-line; further starts are counted as overruns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r      <= 1'b0;
      pend_line_r <= {LINE_NUMBER_WIDTH{1'b0}};
      ovr_cnt_r   <= {OVERRUN_CNT_WIDTH{1'b0}};
    end else if (state_r == ST_IDLE) begin
      pend_r <= 1'b0;
    end else if (line_start) begin
      if (!pend_r) begin
        pend_r      <= 1'b1;
        pend_line_r <= line_number;
      end else if (ovr_cnt_r != OVR_MAX) begin
        ovr_cnt_r <= ovr_cnt_r + {{(OVERRUN_CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign target_line   = target_r;
  assign eval_enable   = eval_en_r;
  assign bg_enable     = bg_en_r;
  assign spr_enable    = spr_en_r;
  assign bus_owner     = owner_r;
  assign buffer_select = buf_sel_r;
  assign line_ready    = ready_r;
  assign busy          = busy_r;
  assign overrun_count = ovr_cnt_r;

endmodule

// File: tb/tb_line_render_scheduler.sv
// Randomized bench for line_render_scheduler: a timeline model derives every output from phase latencies.
module tb_line_render_scheduler;
  localparam int DH = 480;
  localparam int LW = $clog2(DH);
  localparam int OW = 8;
`ifdef PHASE_TIMEOUT_EN
  localparam int TO = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          line_start = 1'b0;
  logic [LW-1:0] line_number = '0;
  logic [LW-1:0] target_line;
  logic          eval_enable, bg_enable, spr_enable;
  logic          eval_done = 1'b0, bg_done = 1'b0, spr_done = 1'b0;
  logic [1:0]    bus_owner;
  logic          buffer_select, line_ready, busy;
  logic [OW-1:0] overrun_count;
`ifdef PHASE_TIMEOUT_EN
  logic          timeout_flag;
`endif

  line_render_scheduler #(
    .DISPLAY_HEIGHT(DH),
`ifdef PHASE_TIMEOUT_EN
    .TIMEOUT_CYCLES(TO),
`endif
    .OVERRUN_CNT_WIDTH(OW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_number(line_number),
    .target_line(target_line), .eval_enable(eval_enable), .eval_done(eval_done),
    .bg_enable(bg_enable), .bg_done(bg_done), .spr_enable(spr_enable), .spr_done(spr_done),
    .bus_owner(bus_owner), .buffer_select(buffer_select), .line_ready(line_ready),
    .busy(busy), .overrun_count(overrun_count)
`ifdef PHASE_TIMEOUT_EN
    , .timeout_flag(timeout_flag)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model: current line accepted so that its first eval cycle is cycle a
  bit act = 1'b0;
  int a = 0;
  int re = 1, rb = 1, rs = 1;
  int le_m = 1, lb_m = 1, ls_m = 1;
  int tgt = 0;
  bit buf_m = 1'b0;
  bit pend = 1'b0;
  int pend_line = 0;
  int ovr = 0;
  int tf_cycle = 1 << 30;
  int lat_e = 1, lat_b = 1, lat_s = 1;

  bit exp_valid = 1'b0;
  int exp_ee, exp_be, exp_se, exp_own, exp_busy, exp_lr, exp_buf, exp_tgt, exp_ovr, exp_tf;

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  function automatic int eff(int raw);
`ifdef PHASE_TIMEOUT_EN
    return (raw > TO) ? TO : raw;
`else
    return raw;
`endif
  endfunction

  function automatic bit model_idle(int c);
    return !act || (c - a >= le_m + lb_m + ls_m + 4);
  endfunction

  task automatic model_outputs(int c);
    int r, t;
    exp_ee = 0; exp_be = 0; exp_se = 0; exp_own = 0; exp_busy = 0; exp_lr = 0;
    exp_buf = buf_m;
    if (act) begin
      r = c - a;
      t = le_m + lb_m + ls_m + 4;
      if (r >= t - 1) exp_buf = !buf_m;
      if (r < t) begin
        exp_busy = 1;
        if (r < le_m) begin
          exp_ee = 1; exp_own = 1;
        end else if (r >= le_m + 1 && r <= le_m + lb_m) begin
          exp_be = 1; exp_own = 2;
        end else if (r >= le_m + lb_m + 2 && r <= le_m + lb_m + ls_m + 1) begin
          exp_se = 1; exp_own = 3;
        end else if (r == t - 1) begin
          exp_lr = 1;
        end
      end
    end
    exp_tgt = tgt;
    exp_ovr = ovr;
    exp_tf = (c >= tf_cycle) ? 1 : 0;
  endtask

  task automatic drive(bit ls_i, int ln_i);
    int src, r, cand;
    bit idle;
    idle = model_idle(cyc);
    line_start = ls_i;
    line_number = LW'(ln_i);
    if (idle && (ls_i || pend)) begin
      src = ls_i ? ln_i : pend_line;
      pend = 1'b0;
      if (act) buf_m = !buf_m;
      act = 1'b1;
      a = cyc + 1;
      tgt = (src + 1 == DH) ? 0 : src + 1;
      re = lat_e; rb = lat_b; rs = lat_s;
      le_m = eff(re); lb_m = eff(rb); ls_m = eff(rs);
      cand = 1 << 30;
`ifdef PHASE_TIMEOUT_EN
      if (re > TO) cand = a + TO;
      else if (rb > TO) cand = a + le_m + 1 + TO;
      else if (rs > TO) cand = a + le_m + lb_m + 2 + TO;
`endif
      if (cand < tf_cycle) tf_cycle = cand;
    end else if (!idle && ls_i) begin
      if (!pend) begin
        pend = 1'b1;
        pend_line = ln_i;
      end else if (ovr < (1 << OW) - 1) begin
        ovr++;
      end
    end
    r = cyc - a;
    eval_done = (act && r == re - 1) ||
                (!(act && r >= 0 && r < le_m) && $urandom_range(0, 3) == 0);
    bg_done   = (act && r == le_m + rb) ||
                (!(act && r >= le_m + 1 && r <= le_m + lb_m) && $urandom_range(0, 3) == 0);
    spr_done  = (act && r == le_m + lb_m + 1 + rs) ||
                (!(act && r >= le_m + lb_m + 2 && r <= le_m + lb_m + ls_m + 1) && $urandom_range(0, 3) == 0);
  endtask

  task automatic step(bit ls_i, int ln_i);
    @(posedge clk);
    #1;
    cyc++;
    model_outputs(cyc);
    exp_valid = 1'b1;
    drive(ls_i, ln_i);
  endtask

  task automatic wait_quiet();
    while (!(model_idle(cyc + 1) && !pend)) step(1'b0, 0);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (exp_valid) begin
      chk("eval_enable", int'(eval_enable), exp_ee);
      chk("bg_enable", int'(bg_enable), exp_be);
      chk("spr_enable", int'(spr_enable), exp_se);
      chk("bus_owner", int'(bus_owner), exp_own);
      chk("busy", int'(busy), exp_busy);
      chk("line_ready", int'(line_ready), exp_lr);
      chk("buffer_select", int'(buffer_select), exp_buf);
      chk("target_line", int'(target_line), exp_tgt);
      chk("overrun_count", int'(overrun_count), exp_ovr);
`ifdef PHASE_TIMEOUT_EN
      chk("timeout_flag", int'(timeout_flag), exp_tf);
`endif
    end
  end

  initial begin
    int a0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovr", int'(overrun_count), 0);
    chk("rst_target", int'(target_line), 0);
    step(1'b0, 0);
    step(1'b0, 0);

    // line 10: eval 5, bg 3, spr 4 cycles
    lat_e = 5; lat_b = 3; lat_s = 4;
    step(1'b1, 10);
    a0 = cyc + 1;
    while (cyc < a0) step(1'b0, 0);
    chk("t1_target", int'(target_line), 11);
    chk("t1_eval_on", int'(eval_enable), 1);
    while (cyc < a0 + 5) step(1'b0, 0);
    chk("t1_gap1_owner", int'(bus_owner), 0);
    step(1'b0, 0);
    chk("t1_bg_on", int'(bg_enable), 1);
    while (cyc < a0 + 14) step(1'b0, 0);
    chk("t1_ready_early", int'(line_ready), 0);
    step(1'b0, 0);
    chk("t1_ready", int'(line_ready), 1);
    chk("t1_buf", int'(buffer_select), 1);
    wait_quiet();

    // wrap at the last visible line
    lat_e = 2; lat_b = 2; lat_s = 2;
    step(1'b1, DH - 1);
    a0 = cyc + 1;
    step(1'b0, 0);
    chk("wrap_target", int'(target_line), 0);
    wait_quiet();

    // queued start during BG, dropped start during SPR
    lat_e = 2; lat_b = 6; lat_s = 3;
    step(1'b1, 5);
    a0 = cyc + 1;
    while (cyc < a0 + 3) step(1'b0, 0);
    step(1'b1, 20);
    while (cyc < a0 + 10) step(1'b0, 0);
    step(1'b1, 33);
    while (cyc < a0 + 15) step(1'b0, 0);
    chk("q_idle_busy", int'(busy), 0);
    chk("q_idle_eval", int'(eval_enable), 0);
    chk("q_ovr", int'(overrun_count), 1);
    step(1'b0, 0);
    chk("q_target", int'(target_line), 21);
    chk("q_eval_on", int'(eval_enable), 1);
    wait_quiet();

    // saturate the overrun counter with a long background phase
    lat_e = 1; lat_b = 320; lat_s = 1;
    step(1'b1, 0);
    a0 = cyc + 1;
    for (int k = 0; k < 400; k++) begin
      step(1'b1, k % DH);
`ifndef PHASE_TIMEOUT_EN
      if (cyc == a0 + 200) chk("bg_hold", int'(bg_enable), 1);
`endif
    end
    step(1'b0, 0);
    chk("ovr_sat", int'(overrun_count), 255);
    wait_quiet();

    // random traffic
    for (int k = 0; k < 2500; k++) begin
      lat_e = $urandom_range(1, 8);
      lat_b = $urandom_range(1, 8);
      lat_s = $urandom_range(1, 8);
      if ($urandom_range(0, 11) == 0)
        step(1'b1, ($urandom_range(0, 7) == 0) ? DH - 1 : $urandom_range(0, DH - 1));
      else
        step(1'b0, 0);
    end
    wait_quiet();

    // asynchronous reset in the middle of EVAL
    lat_e = 6; lat_b = 2; lat_s = 2;
    step(1'b1, 100);
    step(1'b0, 0);
    chk("pre_rst_eval", int'(eval_enable), 1);
    #2;
    exp_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_eval", int'(eval_enable), 0);
    chk("arst_owner", int'(bus_owner), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ovr", int'(overrun_count), 0);
    chk("arst_target", int'(target_line), 0);
    chk("arst_ready", int'(line_ready), 0);
    line_start = 1'b0; eval_done = 1'b0; bg_done = 1'b0; spr_done = 1'b0;
    act = 1'b0; buf_m = 1'b0; tgt = 0; pend = 1'b0; ovr = 0; tf_cycle = 1 << 30;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lat_e = 3; lat_b = 3; lat_s = 3;
    step(1'b0, 0);
    step(1'b1, 7);
    for (int k = 0; k < 30; k++) step(1'b0, 0);
    @(posedge clk);
    #1 exp_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
